// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program-counter stage of the MIPS datapath.
// Holds the fetch PC, forms the branch target (ID-stage PC+4 plus the
// word-aligned offset from shift_left_2), and arbitrates the halt, jump-register,
// jump and branch redirects, in that priority order.
// A redirect takes effect on the next edge. The following cycle is a FLUSH cycle
// that squashes the IF/ID register.
// Optional build macro MISALIGN_TRAP_EN: a jump-register to a target that is not
// word aligned goes to TRAP_VECTOR, and out_misaligned pulses alongside out_flush.
// In the default build the low two bits of the jump-register target are cleared.
// This block has no valid/ready handshake. in_stall is the only flow control:
// while it is high in RUN, the PC holds and every redirect input is ignored.
module pc_branch_unit #(
  parameter int unsigned   MSB         = 31,
  parameter logic [MSB:0]  RESET_PC    = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
  ,
  parameter logic [MSB:0]  TRAP_VECTOR = 32'h0000_0080
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_stall,
  input  logic [MSB:0]  in_pc_plus4_id,
  input  logic [MSB:0]  in_sl2,
  input  logic          in_branch_taken,
  input  logic          in_jump,
  input  logic [25:0]   in_jump_index,
  input  logic          in_jump_reg,
  input  logic [MSB:0]  in_reg_target,
  input  logic          in_halt,
  output logic [MSB:0]  out_pc,
  output logic [MSB:0]  out_pc_plus4,
  output logic          out_flush,
  output logic          out_halted,
`ifdef MISALIGN_TRAP_EN
  output logic          out_misaligned,
`endif
  output logic [1:0]    out_dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  // Clears the low two bits of a jump-register target.
  localparam logic [MSB:0] ALIGN_MASK = {{(MSB-1){1'b1}}, 2'b00};

  state_t        r_state;
  state_t        w_state_next;
  logic [MSB:0]  r_pc;
  logic [MSB:0]  w_pc_next;
  logic [MSB:0]  w_pc_plus4;
  logic [MSB:0]  w_branch_target;
  logic [MSB:0]  w_jump_target;
  logic [MSB:0]  w_jr_target;
`ifdef MISALIGN_TRAP_EN
  logic          r_misaligned;
  logic          w_misaligned_next;
`endif

  // Target candidates. Every add wraps modulo 2^(MSB+1).
  // The signed offset is handled by the two's-complement add.
  always_comb begin
    w_pc_plus4      = r_pc + {{(MSB-2){1'b0}}, 3'd4};
    w_branch_target = in_pc_plus4_id + in_sl2;
    w_jump_target   = {in_pc_plus4_id[MSB:28], in_jump_index, 2'b00};
    w_jr_target     = in_reg_target & ALIGN_MASK;
  end

  // Next-state and next-PC selection. Defaults hold everything.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
`ifdef MISALIGN_TRAP_EN
    w_misaligned_next = 1'b0;
`endif
    case (r_state)
      ST_RUN: begin
        if (!in_stall) begin
          if (in_halt) begin
            w_state_next = ST_HALTED;
          end else if (in_jump_reg) begin
`ifdef MISALIGN_TRAP_EN
            if (in_reg_target[1:0] != 2'b00) begin
              w_pc_next         = TRAP_VECTOR;
              w_misaligned_next = 1'b1;
            end else begin
              w_pc_next = w_jr_target;
            end
`else
            w_pc_next = w_jr_target;
`endif
            w_state_next = ST_FLUSH;
          end else if (in_jump) begin
            w_pc_next    = w_jump_target;
            w_state_next = ST_FLUSH;
          end else if (in_branch_taken) begin
            w_pc_next    = w_branch_target;
            w_state_next = ST_FLUSH;
          end else begin
            w_pc_next = w_pc_plus4;
          end
        end
      end
      ST_FLUSH: begin
        // Redirect inputs here belong to the squashed instruction.
        if (!in_stall) begin
          w_pc_next = w_pc_plus4;
        end
        w_state_next = ST_RUN;
      end
      ST_HALTED: begin
        w_state_next = ST_HALTED;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // State, PC and the misaligned flag registers. Reset dominates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
`ifdef MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
`ifdef MISALIGN_TRAP_EN
      r_misaligned <= w_misaligned_next;
`endif
    end
  end

  // Outputs are decoded from registered state, so they are glitch-free.
  always_comb begin
    out_pc        = r_pc;
    out_pc_plus4  = w_pc_plus4;
    out_flush     = (r_state == ST_FLUSH);
    out_halted    = (r_state == ST_HALTED);
    out_dbg_state = r_state;
`ifdef MISALIGN_TRAP_EN
    out_misaligned = r_misaligned;
`endif
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed scenarios followed by a randomized run.
// Every cycle is compared against a behavioural model of the PC stage.
module tb_pc_branch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0080;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_stall;
  logic [31:0] in_pc_plus4_id;
  logic [31:0] in_sl2;
  logic        in_branch_taken;
  logic        in_jump;
  logic [25:0] in_jump_index;
  logic        in_jump_reg;
  logic [31:0] in_reg_target;
  logic        in_halt;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        out_flush;
  logic        out_halted;
  logic [1:0]  out_dbg_state;
`ifdef MISALIGN_TRAP_EN
  logic        out_misaligned;
`endif

  pc_branch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .in_stall        (in_stall),
    .in_pc_plus4_id  (in_pc_plus4_id),
    .in_sl2          (in_sl2),
    .in_branch_taken (in_branch_taken),
    .in_jump         (in_jump),
    .in_jump_index   (in_jump_index),
    .in_jump_reg     (in_jump_reg),
    .in_reg_target   (in_reg_target),
    .in_halt         (in_halt),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .out_flush       (out_flush),
    .out_halted      (out_halted),
`ifdef MISALIGN_TRAP_EN
    .out_misaligned  (out_misaligned),
`endif
    .out_dbg_state   (out_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // The model sees the stage as a PC plus two facts: "a redirect happened
  // last cycle" (flush) and "the processor is halted".
  logic [31:0] m_pc;
  bit          m_flush;
  bit          m_halted;
  bit          m_mis;

  task automatic model_update();
    bit was_flush;
    was_flush = m_flush;
    m_flush   = 0;
    m_mis     = 0;
    if (reset) begin
      m_pc     = RESET_PC;
      m_halted = 0;
    end else if (m_halted) begin
      // frozen
    end else if (was_flush) begin
      if (!in_stall) m_pc = m_pc + 32'd4;
    end else if (in_stall) begin
      // hold
    end else if (in_halt) begin
      m_halted = 1;
    end else if (in_jump_reg) begin
      m_flush = 1;
`ifdef MISALIGN_TRAP_EN
      if (in_reg_target % 4 != 0) begin
        m_pc  = TRAP_VEC;
        m_mis = 1;
      end else begin
        m_pc = in_reg_target;
      end
`else
      m_pc = in_reg_target - (in_reg_target % 4);
`endif
    end else if (in_jump) begin
      m_flush = 1;
      m_pc = (in_pc_plus4_id & 32'hF000_0000) | ({6'd0, in_jump_index} * 32'd4);
    end else if (in_branch_taken) begin
      m_flush = 1;
      m_pc = in_pc_plus4_id + in_sl2;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    reset = 0; in_stall = 0; in_pc_plus4_id = 0; in_sl2 = 0;
    in_branch_taken = 0; in_jump = 0; in_jump_index = 0;
    in_jump_reg = 0; in_reg_target = 0; in_halt = 0;
  endtask

  // One clock: update the model at the edge, then compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("pc",     out_pc,       m_pc);
    check("pc4",    out_pc_plus4, m_pc + 32'd4);
    check("flush",  {31'd0, out_flush},  {31'd0, m_flush});
    check("halted", {31'd0, out_halted}, {31'd0, m_halted});
`ifdef MISALIGN_TRAP_EN
    check("misaligned", {31'd0, out_misaligned}, {31'd0, m_mis});
`endif
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic randomize_inputs(input bit allow_reset);
    in_stall        = ($urandom_range(0, 3) == 0);
    in_pc_plus4_id  = $urandom() & 32'hFFFF_FFFC;
    in_sl2          = {{14{$urandom_range(0, 1) == 1}}, 16'($urandom()), 2'b00};
    in_branch_taken = ($urandom_range(0, 3) == 0);
    in_jump         = ($urandom_range(0, 5) == 0);
    in_jump_index   = 26'($urandom());
    in_jump_reg     = ($urandom_range(0, 5) == 0);
    in_reg_target   = $urandom();
    in_halt         = ($urandom_range(0, 63) == 0);
    reset           = allow_reset && ($urandom_range(0, 49) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_pc = 32'hDEAD_BEEF; m_flush = 0; m_halted = 0; m_mis = 0;
    clear_inputs();
    @(negedge clk);

    // Reset and free run
    do_reset();
    check("reset_pc", out_pc, 32'h0);
    check("reset_dbg_state", {30'd0, out_dbg_state}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("free_run_pc", out_pc, 32'(i * 4));
    end

    // Branch with negative offset
    in_pc_plus4_id = 32'h20; in_sl2 = 32'hFFFF_FFF0; in_branch_taken = 1;
    step();
    check("branch_target", out_pc, 32'h10);
    check("branch_flush", {31'd0, out_flush}, 32'd1);
    clear_inputs();
    step();
    check("branch_after", out_pc, 32'h14);
    check("branch_flush_end", {31'd0, out_flush}, 32'd0);

    // Jump beats a simultaneous branch
    in_jump = 1; in_jump_index = 26'h40; in_pc_plus4_id = 32'h1000_0004;
    in_branch_taken = 1; in_sl2 = 32'h100;
    step();
    check("jump_wins", out_pc, 32'h1000_0100);
    clear_inputs();
    step();

    // Stall holds the PC and blocks the redirect until released
    do_reset();
    step(); step();
    check("stall_start_pc", out_pc, 32'h8);
    in_stall = 1; in_branch_taken = 1; in_pc_plus4_id = 32'h20; in_sl2 = 32'h40;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_hold_pc", out_pc, 32'h8);
      check("stall_no_flush", {31'd0, out_flush}, 32'd0);
    end
    in_stall = 0;
    step();
    check("stall_release_redirect", out_pc, 32'h60);
    clear_inputs();
    step();

    // Halt freezes the PC; only reset leaves it
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check("halt_start_pc", out_pc, 32'h18);
    in_halt = 1;
    step();
    check("halt_flag", {31'd0, out_halted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      randomize_inputs(0);
      step();
      check("halt_frozen_pc", out_pc, 32'h18);
    end
    clear_inputs();
    do_reset();
    check("halt_reset_pc", out_pc, 32'h0);
    check("halt_reset_flag", {31'd0, out_halted}, 32'd0);

    // Jump-register to a misaligned target
    in_jump_reg = 1; in_reg_target = 32'h0000_0046;
    step();
`ifdef MISALIGN_TRAP_EN
    check("jr_misaligned_trap", out_pc, 32'h80);
    check("jr_misaligned_flag", {31'd0, out_misaligned}, 32'd1);
`else
    check("jr_misaligned_clear", out_pc, 32'h44);
`endif
    clear_inputs();
    step();

    // PC wraps from the top of the address space to zero
    in_jump_reg = 1; in_reg_target = 32'hFFFF_FFFC;
    step();
    check("wrap_top", out_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", out_pc_plus4, 32'h0);
    clear_inputs();
    step();
    check("wrap_zero", out_pc, 32'h0);

    // Reset during a flush cycle
    in_branch_taken = 1; in_pc_plus4_id = 32'h100; in_sl2 = 32'h8;
    step();
    clear_inputs();
    do_reset();
    check("reset_mid_flush_pc", out_pc, 32'h0);
    check("reset_mid_flush_flag", {31'd0, out_flush}, 32'd0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs(1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
